// File: rtl/seq_multiplier_param_pkg.sv
// Shared definitions for the parametrised sequential multiplier:
// FSM state encoding and a counter-width helper.
package seq_mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ACK  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/seq_multiplier_param_if.sv
// Request/result bundle of the sequential multiplier; the requester owns
// start, mode and operands, the multiplier owns status and product.
interface seq_multiplier_param_if #(
  parameter int WIDTH = 8
);
  logic                 start_sig;
  logic                 signed_sig;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy_sig;
  logic                 done_sig;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start_sig, signed_sig, multiplicand, multiplier,
    input  busy_sig, done_sig, product
  );

  modport slave (
    input  start_sig, signed_sig, multiplicand, multiplier,
    output busy_sig, done_sig, product
  );
endinterface

// File: rtl/seq_multiplier_param_twos_abs.sv
// Combinational two's-complement magnitude: the most negative input maps to
// 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
module twos_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign      = value[WIDTH-1];
  assign magnitude = sign ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_multiplier_param.sv
// Shift-add multiplier on sign-stripped magnitudes; the sign is reapplied in
// FIX and a held start_sig is absorbed in ACK so it cannot re-trigger.
module seq_multiplier_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  seq_multiplier_param_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mreg;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             sign_a;
  logic             sign_b;

  twos_abs #(.WIDTH(WIDTH)) abs_a (
    .value     (bus.multiplicand),
    .magnitude (mag_a),
    .sign      (sign_a)
  );

  twos_abs #(.WIDTH(WIDTH)) abs_b (
    .value     (bus.multiplier),
    .magnitude (mag_b),
    .sign      (sign_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mreg      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_sig) begin
            if (bus.signed_sig) begin
              mcand <= {{WIDTH{1'b0}}, mag_a};
              mreg  <= mag_b;
              neg   <= sign_a ^ sign_b;
            end else begin
              mcand <= {{WIDTH{1'b0}}, bus.multiplicand};
              mreg  <= bus.multiplier;
              neg   <= 1'b0;
            end
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mreg[0]) begin
            acc <= acc + mcand;
          end
          mcand <= mcand << 1;
          mreg  <= mreg >> 1;
          cnt   <= cnt + CNT_W'(1);
          // Exit decisions look at the current bits, so the last add is still taken this cycle.
          if ((cnt == LAST) || (EARLY_EXIT && ((mreg >> 1) == '0))) begin
            state <= FIX;
          end
        end
        FIX: begin
          product_q <= neg ? (~acc + PW'(1)) : acc;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= ACK;
        end
        ACK: begin
          if (!bus.start_sig) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_sig = busy_q;
  assign bus.done_sig = done_q;
  assign bus.product  = product_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param: one fixed-latency and one
// early-exit instance at WIDTH=8, plus handshake and reset sequences.
module tb_seq_multiplier_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_f = 1'b0;
  logic       start_e = 1'b0;
  logic       sgn = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier_param_if #(.WIDTH(8)) bus_f ();
  seq_multiplier_param_if #(.WIDTH(8)) bus_e ();

  assign bus_f.start_sig    = start_f;
  assign bus_f.signed_sig   = sgn;
  assign bus_f.multiplicand = op_a;
  assign bus_f.multiplier   = op_b;
  assign bus_e.start_sig    = start_e;
  assign bus_e.signed_sig   = sgn;
  assign bus_e.multiplicand = op_a;
  assign bus_e.multiplier   = op_b;

  seq_multiplier_param #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  seq_multiplier_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
    .clk (clk),
    .rst (rst),
    .bus (bus_e)
  );

  typedef struct {
    string       name;
    logic        early;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic void sample(input logic early, output logic done_now, output logic busy_now,
                                 output logic [15:0] prod_now);
    done_now = early ? bus_e.done_sig : bus_f.done_sig;
    busy_now = early ? bus_e.busy_sig : bus_f.busy_sig;
    prod_now = early ? bus_e.product  : bus_f.product;
  endfunction

  // Latency counts clock edges from the accept edge up to the edge after which done_sig is seen.
  task automatic applyStimulus(input logic early, input logic sgn_in, input logic [7:0] a_in,
                               input logic [7:0] b_in, output logic [15:0] prod, output int lat,
                               output int pulses, output logic busy_ok, output logic held_ok,
                               output logic idle_ok);
    int          guard;
    logic        done_now;
    logic        busy_now;
    logic [15:0] prod_now;
    @(negedge clk);
    sgn  = sgn_in;
    op_a = a_in;
    op_b = b_in;
    if (early) start_e = 1'b1;
    else       start_f = 1'b1;
    lat = 0; pulses = 0; busy_ok = 1'b1; held_ok = 1'b1; prod = '0; guard = 0;
    do begin
      @(posedge clk); #1;
      lat++; guard++;
      sample(early, done_now, busy_now, prod_now);
      if (!busy_now) busy_ok = 1'b0;
    end while (!done_now && guard < 40);
    if (done_now) begin
      pulses = 1;
      prod   = prod_now;
    end else begin
      lat = -1;
    end
    start_f = 1'b0;
    start_e = 1'b0;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
      sample(early, done_now, busy_now, prod_now);
      if (done_now) pulses++;
      if (prod_now !== prod) held_ok = 1'b0;
    end while (busy_now && guard < 20);
    idle_ok = !busy_now;
  endtask

  initial begin
    logic [15:0] prod;
    int          lat;
    int          pulses;
    logic        busy_ok;
    logic        held_ok;
    logic        idle_ok;
    int          guard;
    int          extra;
    logic        all_busy;

    vecs[0]  = '{"u_10x2",     1'b0, 1'b0, 8'h0A, 8'h02, 16'h0014, 10};
    vecs[1]  = '{"s_11xm5",    1'b0, 1'b1, 8'h0B, 8'hFB, 16'hFFC9, 10};
    vecs[2]  = '{"s_m5xm11",   1'b0, 1'b1, 8'hFB, 8'hF5, 16'h0037, 10};
    vecs[3]  = '{"u_FBxF5",    1'b0, 1'b0, 8'hFB, 8'hF5, 16'hF037, 10};
    vecs[4]  = '{"s_m128sq",   1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 10};
    vecs[5]  = '{"s_m128x1",   1'b0, 1'b1, 8'h80, 8'h01, 16'hFF80, 10};
    vecs[6]  = '{"u_FFxFF",    1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 10};
    vecs[7]  = '{"e_10x2",     1'b1, 1'b0, 8'h0A, 8'h02, 16'h0014, 4};
    vecs[8]  = '{"e_7x0",      1'b1, 1'b0, 8'h07, 8'h00, 16'h0000, 3};
    vecs[9]  = '{"e_1xm128",   1'b1, 1'b1, 8'h01, 8'h80, 16'hFF80, 10};
    vecs[10] = '{"e_3xm3",     1'b1, 1'b1, 8'h03, 8'hFD, 16'hFFF7, 4};
    vecs[11] = '{"e_5x16",     1'b1, 1'b0, 8'h05, 8'h10, 16'h0050, 7};

    #1;
    checkOutput("reset_busy_f", 32'(bus_f.busy_sig), 32'd0);
    checkOutput("reset_done_f", 32'(bus_f.done_sig), 32'd0);
    checkOutput("reset_prod_f", 32'(bus_f.product), 32'd0);
    checkOutput("reset_prod_e", 32'(bus_e.product), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].early, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    prod, lat, pulses, busy_ok, held_ok, idle_ok);
      checkOutput({vecs[i].name, "_prod"}, 32'(prod), 32'(vecs[i].prod));
      checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({vecs[i].name, "_pulses"}, 32'(pulses), 32'd1);
      checkOutput({vecs[i].name, "_busy"}, 32'(busy_ok), 32'd1);
      checkOutput({vecs[i].name, "_held"}, 32'(held_ok), 32'd1);
      checkOutput({vecs[i].name, "_idle"}, 32'(idle_ok), 32'd1);
    end

    // Held start: the multiplier must park in ACK until start_sig drops.
    @(negedge clk);
    sgn = 1'b1; op_a = 8'h0B; op_b = 8'hFB; start_f = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #1; guard++;
    end while (!bus_f.done_sig && guard < 40);
    checkOutput("hold_first_done", 32'(bus_f.done_sig), 32'd1);
    checkOutput("hold_first_prod", 32'(bus_f.product), 32'h0000FFC9);
    extra = 0; all_busy = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_f.done_sig) extra++;
      if (!bus_f.busy_sig) all_busy = 1'b0;
    end
    checkOutput("hold_no_redone", 32'(extra), 32'd0);
    checkOutput("hold_busy", 32'(all_busy), 32'd1);
    @(negedge clk);
    start_f = 1'b0;
    guard = 0;
    do begin
      @(posedge clk); #1; guard++;
    end while (bus_f.busy_sig && guard < 5);
    checkOutput("hold_release_idle", 32'(bus_f.busy_sig), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h03, 8'h05, prod, lat, pulses, busy_ok, held_ok, idle_ok);
    checkOutput("hold_second_prod", 32'(prod), 32'h0000000F);
    checkOutput("hold_second_lat", 32'(lat), 32'd10);

    // Reset in the middle of CALC must discard the partial result.
    @(negedge clk);
    sgn = 1'b0; op_a = 8'h0A; op_b = 8'h02; start_f = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    start_f = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus_f.busy_sig), 32'd0);
    checkOutput("midrst_done", 32'(bus_f.done_sig), 32'd0);
    checkOutput("midrst_prod", 32'(bus_f.product), 32'd0);
    #3;
    rst = 1'b0;
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus_f.done_sig) extra++;
    end
    checkOutput("midrst_no_done", 32'(extra), 32'd0);
    checkOutput("midrst_prod_after", 32'(bus_f.product), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'hF5, 8'h07, prod, lat, pulses, busy_ok, held_ok, idle_ok);
    checkOutput("recover_prod", 32'(prod), 32'h0000FFB3);
    checkOutput("recover_lat", 32'(lat), 32'd10);
    checkOutput("recover_pulses", 32'(pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
